// File: rtl/holosynth_audio_serializer_if.sv
// Frame handshake between the synth sample path and the audio serializer.
// One transfer carries a full frame, channel 0 in the LSBs.
interface holosynth_audio_serializer_if #(
  parameter int unsigned DataW = 48
) ();
  logic             in_valid;
  logic             in_ready;
  logic [DataW-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/holosynth_audio_serializer.sv
// N-channel I2S / left-justified / TDM serializer with internal BCLK/LRCK generation,
// a one-deep frame buffer and underrun accounting.
module holosynth_audio_serializer #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned AUD_BIT_DEPTH = 24,
  parameter int unsigned SLOT_BITS     = 32,
  parameter int unsigned BCLK_DIV      = 8,
  parameter int unsigned MODE          = 0
) (
  input  logic                              fpga_clk,
  input  logic                              reset_n,
  input  logic                              run,
  input  logic                              mute,
  holosynth_audio_serializer_if.slave       in_if,
  output logic                              aud_bclk,
  output logic                              aud_lrck,
  output logic                              aud_dout,
  output logic                              frame_start,
  output logic                              underrun,
  output logic [7:0]                        underrun_cnt,
  input  logic                              clr_underrun
);
  localparam int unsigned DataW = NUM_CH * AUD_BIT_DEPTH;
  localparam int unsigned Pad   = SLOT_BITS - AUD_BIT_DEPTH;
  localparam int unsigned DivW  = $clog2(BCLK_DIV);
  localparam int unsigned BitW  = $clog2(SLOT_BITS);
  localparam int unsigned SlotW = $clog2(NUM_CH);

  localparam logic [DivW-1:0]  DivMax   = DivW'(BCLK_DIV - 1);
  localparam logic [DivW-1:0]  DivHalf  = DivW'(BCLK_DIV / 2);
  localparam logic [BitW-1:0]  BitMax   = BitW'(SLOT_BITS - 1);
  localparam logic [SlotW-1:0] SlotMax  = SlotW'(NUM_CH - 1);
  localparam logic [SlotW-1:0] SlotHalf = SlotW'(NUM_CH / 2);

  typedef logic [NUM_CH-1:0][SLOT_BITS-1:0] frame_t;

  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic             bclk_q, bclk_d, lrck_q, lrck_d, dout_q, dout_d, fs_q, fs_d;
  logic [DataW-1:0] buf_q, buf_d;
  logic             full_q, full_d, primed_q, primed_d, ur_q, ur_d;
  logic [7:0]       ucnt_q, ucnt_d;
  frame_t           words_q, words_d, load_words;
  logic             tick, boundary, accept;

  always_comb begin
    div_d      = div_q;
    bit_d      = bit_q;
    slot_d     = slot_q;
    bclk_d     = bclk_q;
    lrck_d     = lrck_q;
    dout_d     = dout_q;
    fs_d       = 1'b0;
    buf_d      = buf_q;
    full_d     = full_q;
    primed_d   = primed_q;
    ur_d       = ur_q;
    ucnt_d     = ucnt_q;
    words_d    = words_q;
    load_words = '0;

    tick     = run && (div_q == DivMax);
    boundary = tick && (bit_q == '0) && (slot_q == '0);
    accept   = in_if.in_valid && !full_q;

    for (int k = 0; k < NUM_CH; k++) begin
      if (full_q && !mute) begin
        load_words[k] = SLOT_BITS'(buf_q[k*AUD_BIT_DEPTH +: AUD_BIT_DEPTH]) << Pad;
      end
    end

    if (boundary) begin
      words_d = load_words;
      if (full_q) begin
        full_d   = 1'b0;
        primed_d = 1'b1;
      end else if (primed_q) begin
        ur_d   = 1'b1;
        ucnt_d = (ucnt_q == 8'hFF) ? ucnt_q : ucnt_q + 8'd1;
      end
    end

    // Ready is low while full, so an accept never collides with a transfer.
    if (accept) begin
      full_d = 1'b1;
      buf_d  = in_if.in_data;
    end

    if (clr_underrun) begin
      ur_d   = 1'b0;
      ucnt_d = '0;
    end

    if (!run) begin
      div_d  = '0;
      bit_d  = '0;
      slot_d = '0;
      bclk_d = 1'b0;
      lrck_d = 1'b0;
      dout_d = 1'b0;
    end else begin
      div_d  = tick ? '0 : div_q + DivW'(1);
      bclk_d = (div_d >= DivHalf);
      fs_d   = boundary;
      if (tick) begin
        bit_d = (bit_q == BitMax) ? '0 : bit_q + BitW'(1);
        if (bit_q == BitMax) begin
          slot_d = (slot_q == SlotMax) ? '0 : slot_q + SlotW'(1);
        end
        lrck_d = (MODE == 2) ? ((bit_q == '0) && (slot_q == '0)) : (slot_q >= SlotHalf);
        if (MODE == 0) begin
          // I2S lags by one bit: bit 0 of a slot carries the LSB of the slot before it.
          if (bit_q == '0) begin
            dout_d = (slot_q == '0) ? words_q[NUM_CH-1][0] : words_q[slot_q - SlotW'(1)][0];
          end else begin
            dout_d = words_q[slot_q][BitW'(SLOT_BITS) - bit_q];
          end
        end else begin
          dout_d = words_d[slot_q][BitMax - bit_q];
        end
      end
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      div_q    <= '0;
      bit_q    <= '0;
      slot_q   <= '0;
      bclk_q   <= 1'b0;
      lrck_q   <= 1'b0;
      dout_q   <= 1'b0;
      fs_q     <= 1'b0;
      buf_q    <= '0;
      full_q   <= 1'b0;
      primed_q <= 1'b0;
      ur_q     <= 1'b0;
      ucnt_q   <= '0;
      words_q  <= '0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      slot_q   <= slot_d;
      bclk_q   <= bclk_d;
      lrck_q   <= lrck_d;
      dout_q   <= dout_d;
      fs_q     <= fs_d;
      buf_q    <= buf_d;
      full_q   <= full_d;
      primed_q <= primed_d;
      ur_q     <= ur_d;
      ucnt_q   <= ucnt_d;
      words_q  <= words_d;
    end
  end

  assign in_if.in_ready = !full_q;
  assign aud_bclk       = bclk_q;
  assign aud_lrck       = lrck_q;
  assign aud_dout       = dout_q;
  assign frame_start    = fs_q;
  assign underrun       = ur_q;
  assign underrun_cnt   = ucnt_q;
endmodule

// File: tb/tb_holosynth_audio_serializer.sv
// Bench for holosynth_audio_serializer: I2S and left-justified stereo units share stimulus,
// an 8-channel TDM unit runs alongside; a timeline model predicts every output each cycle.
module tb_holosynth_audio_serializer;
  localparam int Div  = 8;
  localparam int Slot = 32;
  localparam int Dep  = 24;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         runA = 1'b0, muteA = 1'b0, clrA = 1'b0, vA = 1'b0;
  logic         runB = 1'b0, vB = 1'b0;
  logic [47:0]  dA = '0;
  logic [191:0] dB = '0;
  logic [2:0]   bclk_w, lrck_w, dout_w, fs_w, rdy_w, ur_w;
  logic [2:0][7:0] ucnt_w;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  holosynth_audio_serializer_if #(.DataW(48))  if0 ();
  holosynth_audio_serializer_if #(.DataW(48))  if1 ();
  holosynth_audio_serializer_if #(.DataW(192)) if2 ();
  assign if0.in_valid = vA;
  assign if0.in_data  = dA;
  assign if1.in_valid = vA;
  assign if1.in_data  = dA;
  assign if2.in_valid = vB;
  assign if2.in_data  = dB;
  assign rdy_w = {if2.in_ready, if1.in_ready, if0.in_ready};

  holosynth_audio_serializer #(.NUM_CH(2), .MODE(0)) dut0 (
    .fpga_clk(clk), .reset_n(rst_n), .run(runA), .mute(muteA), .in_if(if0),
    .aud_bclk(bclk_w[0]), .aud_lrck(lrck_w[0]), .aud_dout(dout_w[0]), .frame_start(fs_w[0]),
    .underrun(ur_w[0]), .underrun_cnt(ucnt_w[0]), .clr_underrun(clrA));
  holosynth_audio_serializer #(.NUM_CH(2), .MODE(1)) dut1 (
    .fpga_clk(clk), .reset_n(rst_n), .run(runA), .mute(muteA), .in_if(if1),
    .aud_bclk(bclk_w[1]), .aud_lrck(lrck_w[1]), .aud_dout(dout_w[1]), .frame_start(fs_w[1]),
    .underrun(ur_w[1]), .underrun_cnt(ucnt_w[1]), .clr_underrun(clrA));
  holosynth_audio_serializer #(.NUM_CH(8), .MODE(2)) dut2 (
    .fpga_clk(clk), .reset_n(rst_n), .run(runB), .mute(1'b0), .in_if(if2),
    .aud_bclk(bclk_w[2]), .aud_lrck(lrck_w[2]), .aud_dout(dout_w[2]), .frame_start(fs_w[2]),
    .underrun(ur_w[2]), .underrun_cnt(ucnt_w[2]), .clr_underrun(1'b0));

  // Reference model state, one entry per DUT.
  logic         m_full[3], m_primed[3], m_uflag[3], prev_lsb[3], acc_seen[3];
  int           m_ucnt[3], rc[3];
  logic [191:0] m_data[3];
  logic [31:0]  cur_w[3][8];

  function automatic int nch(input int k);
    return (k == 2) ? 8 : 2;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Bit q of the current frame's serial stream, slot 0 MSB first.
  function automatic logic sbit(input int k, input int q);
    logic [31:0] w;
    w = cur_w[k][q / Slot];
    return w[31 - (q % Slot)];
  endfunction

  task automatic mon_step(input int k);
    logic v, runv, mutev, clrv, acc, bnd, eb, el, ed;
    logic [191:0] d;
    int fb, p;
    v     = (k < 2) ? vA : vB;
    d     = (k < 2) ? {144'b0, dA} : dB;
    runv  = (k < 2) ? runA : runB;
    mutev = (k < 2) ? muteA : 1'b0;
    clrv  = (k < 2) ? clrA : 1'b0;
    fb    = nch(k) * Slot;
    bnd   = 1'b0;
    if (!rst_n) begin
      m_full[k] = 0; m_primed[k] = 0; m_uflag[k] = 0; prev_lsb[k] = 0;
      m_ucnt[k] = 0; rc[k] = 0; m_data[k] = '0;
      for (int c = 0; c < 8; c++) cur_w[k][c] = '0;
    end else begin
      acc = v && !m_full[k];
      if (runv) begin
        rc[k]++;
        bnd = (rc[k] >= Div) && (((rc[k] - Div) % (Div * fb)) == 0);
      end else begin
        rc[k] = 0;
      end
      if (bnd) begin
        prev_lsb[k] = cur_w[k][nch(k) - 1][0];
        for (int c = 0; c < 8; c++)
          cur_w[k][c] = (m_full[k] && !mutev && c < nch(k)) ?
                        (32'(m_data[k][c*Dep +: Dep]) << (Slot - Dep)) : 32'd0;
        if (m_full[k]) begin
          m_full[k] = 0; m_primed[k] = 1;
        end else if (m_primed[k]) begin
          m_uflag[k] = 1;
          if (m_ucnt[k] < 255) m_ucnt[k]++;
        end
      end
      if (clrv) begin
        m_uflag[k] = 0; m_ucnt[k] = 0;
      end
      if (acc) begin
        m_full[k] = 1; m_data[k] = d;
        if (k != 1) acc_seen[k] = 1;
      end
    end
    eb = 0; el = 0; ed = 0;
    if (rst_n && runv) begin
      eb = (rc[k] % Div) >= (Div / 2);
      if (rc[k] >= Div) begin
        p  = ((rc[k] - Div) / Div) % fb;
        el = (k == 2) ? (p == 0) : ((p / Slot) >= (nch(k) / 2));
        if (k == 0) ed = (p == 0) ? prev_lsb[k] : sbit(k, p - 1);
        else        ed = sbit(k, p);
      end
    end
    check("in_ready", k, 32'(rdy_w[k]), 32'(!m_full[k]));
    check("frame_start", k, 32'(fs_w[k]), 32'(bnd));
    check("aud_bclk", k, 32'(bclk_w[k]), 32'(eb));
    check("aud_lrck", k, 32'(lrck_w[k]), 32'(el));
    check("aud_dout", k, 32'(dout_w[k]), 32'(ed));
    check("underrun", k, 32'(ur_w[k]), 32'(m_uflag[k]));
    check("underrun_cnt", k, 32'(ucnt_w[k]), 32'(m_ucnt[k]));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) mon_step(k);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_fs(input int k, input int n);
    int   seen;
    logic prev;
    seen = 0;
    prev = fs_w[k];
    for (int i = 0; i < n * 2100 + 50 && seen < n; i++) begin
      @(negedge clk);
      if (fs_w[k] && !prev) seen++;
      prev = fs_w[k];
    end
    check("fs_wait", k, 32'(seen), 32'(n));
  endtask

  task automatic send_frame(input int k, input logic [191:0] data, input logic keep);
    logic ok;
    acc_seen[k] = 0;
    if (k == 0) begin dA = data[47:0]; vA = 1'b1; end
    else        begin dB = data;       vB = 1'b1; end
    ok = 0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge clk);
      ok = acc_seen[k];
    end
    check("accept_wait", k, 32'(ok), 32'd1);
    if (!keep) begin
      if (k == 0) vA = 1'b0; else vB = 1'b0;
    end
  endtask

  // Captures the next stereo frame from the I2S (w0*) and left-justified (w1*) units.
  task automatic capture_a(output logic [31:0] w0l, output logic [31:0] w0r,
                           output logic [31:0] w1l, output logic [31:0] w1r);
    logic [64:0] s0, s1;
    logic prev;
    int   n;
    s0 = '0; s1 = '0; n = 0;
    wait_fs(0, 1);
    prev = bclk_w[0];
    for (int i = 0; i < 65 * Div * 2 && n < 65; i++) begin
      @(negedge clk);
      if (bclk_w[0] && !prev) begin
        s0[n] = dout_w[0];
        s1[n] = dout_w[1];
        n++;
      end
      prev = bclk_w[0];
    end
    check("capture_bits", 0, 32'(n), 32'd65);
    for (int j = 0; j < 32; j++) begin
      w1l[31-j] = s1[j];
      w1r[31-j] = s1[32+j];
      w0l[31-j] = s0[j+1];
      w0r[31-j] = s0[33+j];
    end
  endtask

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        mute;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  initial begin
    vec_t tbl[4];
    logic [31:0] w0l, w0r, w1l, w1r;
    logic [191:0] d;
    logic [31:0] tw[8];
    logic prev;
    int n, lr_hi;

    tbl[0] = '{l: 24'h800001, r: 24'h7FFFFF, mute: 1'b0, exp_l: 32'h8000_0100, exp_r: 32'h7FFF_FF00};
    tbl[1] = '{l: 24'h000000, r: 24'hFFFFFF, mute: 1'b0, exp_l: 32'h0000_0000, exp_r: 32'hFFFF_FF00};
    tbl[2] = '{l: 24'h123456, r: 24'hABCDEF, mute: 1'b1, exp_l: 32'h0000_0000, exp_r: 32'h0000_0000};
    tbl[3] = '{l: 24'hA5A5A5, r: 24'h5A5A5A, mute: 1'b0, exp_l: 32'hA5A5_A500, exp_r: 32'h5A5A_5A00};

    repeat (4) @(negedge clk);
    check("reset_ready", 0, 32'(rdy_w[0]), 32'd1);
    check("reset_outs", 0, 32'({bclk_w, lrck_w, dout_w, fs_w, ur_w}), 32'd0);
    rst_n = 1'b1;
    runA  = 1'b1;
    runB  = 1'b1;

    // Unprimed frames after reset must not count as underruns.
    wait_fs(0, 3);
    check("no_underrun_unprimed", 0, 32'(ucnt_w[0]), 32'd0);
    check("no_underrun_flag", 0, 32'(ur_w[0]), 32'd0);

    for (int i = 0; i < 4; i++) begin
      muteA = tbl[i].mute;
      send_frame(0, {144'b0, tbl[i].r, tbl[i].l}, 1'b0);
      capture_a(w0l, w0r, w1l, w1r);
      muteA = 1'b0;
      check("tbl_lj_left", 1, w1l, tbl[i].exp_l);
      check("tbl_lj_right", 1, w1r, tbl[i].exp_r);
      check("tbl_i2s_left", 0, w0l, tbl[i].exp_l);
      check("tbl_i2s_right", 0, w0r, tbl[i].exp_r);
    end

    // Prime, then starve for three frames.
    send_frame(0, {144'b0, 48'h111111_222222}, 1'b0);
    wait_fs(0, 1);
    clrA = 1'b1;
    @(negedge clk);
    clrA = 1'b0;
    wait_fs(0, 3);
    check("underrun_cnt_3", 0, 32'(ucnt_w[0]), 32'd3);
    check("underrun_flag", 0, 32'(ur_w[0]), 32'd1);
    clrA = 1'b1;
    @(negedge clk);
    clrA = 1'b0;
    @(negedge clk);
    check("underrun_clr", 0, 32'(ucnt_w[0]), 32'd0);
    check("underrun_clr_flag", 0, 32'(ur_w[0]), 32'd0);

    // Back-to-back frames with in_valid held high.
    for (int i = 0; i < 6; i++)
      send_frame(0, {144'b0, 16'($urandom), $urandom}, (i < 5) ? 1'b1 : 1'b0);
    wait_fs(0, 2);

    // Stop mid-frame with a frame buffered; it must go out intact after restart.
    wait_fs(0, 1);
    d = {144'b0, 16'($urandom), $urandom};
    send_frame(0, d, 1'b0);
    repeat (100) @(negedge clk);
    runA = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_outs", 0, 32'({bclk_w[1:0], lrck_w[1:0], dout_w[1:0], fs_w[1:0]}), 32'd0);
    check("idle_ready", 0, 32'(rdy_w[0]), 32'd0);
    runA = 1'b1;
    capture_a(w0l, w0r, w1l, w1r);
    check("restart_lj_left", 1, w1l, 32'(d[23:0]) << 8);
    check("restart_lj_right", 1, w1r, 32'(d[47:24]) << 8);
    check("restart_i2s_left", 0, w0l, 32'(d[23:0]) << 8);

    // Random frames, gaps, mute and clears against the model.
    for (int i = 0; i < 10; i++) begin
      muteA = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 600)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        clrA = 1'b1;
        @(negedge clk);
        clrA = 1'b0;
      end
      send_frame(0, {144'b0, 16'($urandom), $urandom}, 1'b0);
    end
    muteA = 1'b0;
    wait_fs(0, 2);

    // TDM: channel k carries k+1.
    d = '0;
    for (int c = 0; c < 8; c++) d[c*Dep +: Dep] = 24'(c + 1);
    send_frame(2, d, 1'b0);
    wait_fs(2, 1);
    for (int c = 0; c < 8; c++) tw[c] = '0;
    n = 0; lr_hi = 0;
    prev = bclk_w[2];
    for (int i = 0; i < 256 * Div * 2 && n < 256; i++) begin
      @(negedge clk);
      if (bclk_w[2] && !prev) begin
        tw[n / Slot][31 - (n % Slot)] = dout_w[2];
        if (lrck_w[2]) lr_hi++;
        n++;
      end
      prev = bclk_w[2];
    end
    check("tdm_bits", 2, 32'(n), 32'd256);
    check("tdm_lrck_high_bclks", 2, 32'(lr_hi), 32'd1);
    for (int c = 0; c < 8; c++) check("tdm_slot", 2, tw[c], 32'(c + 1) << 8);

    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
